// File: rtl/buffer3_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : buf3_pkg
// Description : Shared defaults and state encoding for the 3-line window
//               buffer sequencer. Define VGA_640x480p60 to select the
//               640x480 frame geometry instead of 800x600.
// Revision    : 1.0 - initial release
// ============================================================================
package buf3_pkg;

`ifdef VGA_640x480p60
  localparam int c_DEF_WIDTH  = 640;
  localparam int c_DEF_HEIGHT = 480;
`else
  localparam int c_DEF_WIDTH  = 800;
  localparam int c_DEF_HEIGHT = 600;
`endif

  // 10 bits per RGB channel
  localparam int c_DEF_PIX_W  = 30;
  // 2^CW must exceed max(WIDTH, HEIGHT)
  localparam int c_DEF_CW     = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/buffer3_ctrl_wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : wrap_counter
// Description : Column/row counter pair. x runs 0..XMAX and wraps into y,
//               y runs 0..YMAX and wraps to 0. o_last flags (XMAX, YMAX).
//               A clear together with an enable restarts the sequence at
//               its first step (x=1, y=0) so the element being counted in
//               the clearing cycle is included. Requires XMAX >= 1.
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_counter #(
  parameter int XMAX = 7,
  parameter int YMAX = 3,
  parameter int CW   = 12
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_last
);

  localparam logic [CW-1:0] c_XMAX = CW'(XMAX);
  localparam logic [CW-1:0] c_YMAX = CW'(YMAX);

  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          w_xwrap;
  logic          w_ywrap;

  assign w_xwrap = (r_x == c_XMAX);
  assign w_ywrap = (r_y == c_YMAX);

  // Count position; clear wins over enable and restarts at the first step
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clr) begin
      r_x <= i_en ? CW'(1) : '0;
      r_y <= '0;
    end else if (i_en) begin
      if (w_xwrap) begin
        r_x <= '0;
        r_y <= w_ywrap ? '0 : r_y + CW'(1);
      end else begin
        r_x <= r_x + CW'(1);
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = w_xwrap & w_ywrap;

endmodule
`default_nettype wire

// File: rtl/buffer3_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : buffer3_ctrl
// Description : Sequencer for the 3-line window buffer of the edge-detection
//               path. Accepts the pixel stream, drives the buffer's clken and
//               shiftin, tracks the window centre and flushes the buffer with
//               zero pixels at end of frame.
//               Optional: define BUF3CTRL_BORDER_EN to build the o_border
//               flag; otherwise o_border is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module buffer3_ctrl
  import buf3_pkg::*;
#(
  parameter int WIDTH  = c_DEF_WIDTH,
  parameter int HEIGHT = c_DEF_HEIGHT,
  parameter int PIX_W  = c_DEF_PIX_W,
  parameter int CW     = c_DEF_CW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_sof,
  input  logic             i_valid,
  input  logic [PIX_W-1:0] i_pixel,
  output logic             o_ready,
  output logic             buf_clken,
  output logic [PIX_W-1:0] buf_shiftin,
  output logic             o_win_valid,
  output logic [CW-1:0]    o_x,
  output logic [CW-1:0]    o_y,
  output logic             o_eof,
  output logic             o_border,
  output logic             o_busy
);

  // Input count of 2*WIDTH-2 is column WIDTH-2 of row 1
  localparam logic [CW-1:0] c_FILL_X = CW'(WIDTH - 2);
  localparam logic [CW-1:0] c_FILL_Y = CW'(1);

  state_t        r_state;
  state_t        w_state_nxt;

  logic          w_accept;
  logic          w_flush;
  logic          w_restart;
  logic          w_fill_done;
  logic          w_run_shift;
  logic          w_emit;
  logic          w_in_en;
  logic          w_c_en;

  logic [CW-1:0] w_in_x;
  logic [CW-1:0] w_in_y;
  logic          w_in_last;
  logic [CW-1:0] w_c_x;
  logic [CW-1:0] w_c_y;
  logic          w_c_last;

  logic          r_win_valid;
  logic          r_eof;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;

  assign w_flush     = (r_state == FLUSH);
  assign o_ready     = ~w_flush;
  assign w_accept    = i_valid & o_ready;
  assign w_restart   = w_accept & i_sof;
  assign buf_clken   = w_accept | w_flush;
  assign buf_shiftin = w_flush ? '0 : i_pixel;
  assign o_busy      = (r_state != IDLE);

  // Pixels accepted since sof (k), modulo the frame size
  assign w_in_en = w_accept & (i_sof | (r_state == FILL) | (r_state == RUN));

  wrap_counter #(
    .XMAX (WIDTH - 1),
    .YMAX (HEIGHT - 1),
    .CW   (CW)
  ) u_in_cnt (
    .clock  (clock),
    .reset  (reset),
    .i_clr  (w_restart),
    .i_en   (w_in_en),
    .o_x    (w_in_x),
    .o_y    (w_in_y),
    .o_last (w_in_last)
  );

  // Coordinate of the next window to be emitted (one ahead of o_x/o_y)
  assign w_emit = w_run_shift | w_flush;
  assign w_c_en = w_fill_done | w_emit;

  wrap_counter #(
    .XMAX (WIDTH - 1),
    .YMAX (HEIGHT - 1),
    .CW   (CW)
  ) u_ctr_cnt (
    .clock  (clock),
    .reset  (reset),
    .i_clr  (w_fill_done),
    .i_en   (w_c_en),
    .o_x    (w_c_x),
    .o_y    (w_c_y),
    .o_last (w_c_last)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-cycle shift strobes; sof always restarts the frame
  always_comb begin
    w_state_nxt = r_state;
    w_fill_done = 1'b0;
    w_run_shift = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_restart) w_state_nxt = FILL;
      end
      FILL: begin
        if (w_restart) begin
          w_state_nxt = FILL;
        end else if (w_accept && (w_in_x == c_FILL_X) && (w_in_y == c_FILL_Y)) begin
          w_fill_done = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_restart) begin
          w_state_nxt = FILL;
        end else if (w_accept) begin
          w_run_shift = 1'b1;
          if (w_in_last) w_state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (w_c_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Window qualifiers updated on the edge that shifts the buffer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_win_valid <= 1'b0;
      r_eof       <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
    end else begin
      r_win_valid <= w_fill_done | w_emit;
      r_eof       <= w_flush & w_c_last;
      if (w_fill_done) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_emit) begin
        r_x <= w_c_x;
        r_y <= w_c_y;
      end
    end
  end

  assign o_win_valid = r_win_valid;
  assign o_eof       = r_eof;
  assign o_x         = r_x;
  assign o_y         = r_y;

`ifdef BUF3CTRL_BORDER_EN
  localparam logic [CW-1:0] c_XMAX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] c_YMAX = CW'(HEIGHT - 1);

  logic r_border;
  logic w_c_edge;

  assign w_c_edge = (w_c_x == '0) | (w_c_x == c_XMAX) | (w_c_y == '0) | (w_c_y == c_YMAX);

  // Border flag for the coordinate being loaded into o_x/o_y
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_border <= 1'b0;
    end else begin
      r_border <= w_fill_done | (w_emit & w_c_edge);
    end
  end

  assign o_border = r_border;
`else
  assign o_border = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_buffer3_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_buffer3_ctrl
// Description : Self-checking bench for buffer3_ctrl (WIDTH=8, HEIGHT=4).
//               Expected window positions are derived from the frame index of
//               the centre pixel, p = k + 1 - 2*WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buffer3_ctrl;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int PW = 30;
  localparam int CB = 12;
`ifdef BUF3CTRL_BORDER_EN
  localparam bit c_BORDER_ON = 1'b1;
  localparam int c_EXP_BORDER = 20;
`else
  localparam bit c_BORDER_ON = 1'b0;
  localparam int c_EXP_BORDER = 0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          i_sof;
  logic          i_valid;
  logic [PW-1:0] i_pixel;
  logic          o_ready;
  logic          buf_clken;
  logic [PW-1:0] buf_shiftin;
  logic          o_win_valid;
  logic [CB-1:0] o_x;
  logic [CB-1:0] o_y;
  logic          o_eof;
  logic          o_border;
  logic          o_busy;

  buffer3_ctrl #(
    .WIDTH  (W),
    .HEIGHT (H),
    .PIX_W  (PW),
    .CW     (CB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .i_sof       (i_sof),
    .i_valid     (i_valid),
    .i_pixel     (i_pixel),
    .o_ready     (o_ready),
    .buf_clken   (buf_clken),
    .buf_shiftin (buf_shiftin),
    .o_win_valid (o_win_valid),
    .o_x         (o_x),
    .o_y         (o_y),
    .o_eof       (o_eof),
    .o_border    (o_border),
    .o_busy      (o_busy)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: frame activity, shift count k, and expected outputs
  bit m_in_frame;
  bit m_flush;
  int m_k;
  bit e_wv;
  int e_x;
  int e_y;
  bit e_eof;
  bit e_border;

  int obs_win;
  int obs_border;
  int obs_flush;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in_frame = 0;
    m_flush    = 0;
    m_k        = 0;
    e_wv       = 0;
    e_x        = 0;
    e_y        = 0;
    e_eof      = 0;
    e_border   = 0;
  endtask

  task automatic clear_obs();
    obs_win    = 0;
    obs_border = 0;
    obs_flush  = 0;
  endtask

  task automatic set_win(input int p);
    e_wv = 1;
    e_x  = p % W;
    e_y  = p / W;
  endtask

  // One clock: drive inputs, check combinational outputs, advance model, check registered outputs
  task automatic step(input bit v, input bit s, input logic [PW-1:0] pix);
    bit acc;
    int p;
    @(negedge clock);
    i_valid = v;
    i_sof   = s;
    i_pixel = pix;
    #1;
    check_val("ready",   32'(o_ready),   32'(!m_flush));
    check_val("busy",    32'(o_busy),    32'(m_in_frame | m_flush));
    check_val("clken",   32'(buf_clken), 32'((v & !m_flush) | m_flush));
    check_val("shiftin", 32'(buf_shiftin), m_flush ? 32'd0 : 32'(pix));
    if (!o_ready) obs_flush++;
    acc   = v & !m_flush;
    e_wv  = 0;
    e_eof = 0;
    if (m_flush) begin
      m_k++;
      p = m_k + 1 - 2 * W;
      set_win(p);
      if (p == W * H - 1) begin
        e_eof      = 1;
        m_flush    = 0;
        m_in_frame = 0;
      end
    end else if (acc && s) begin
      m_in_frame = 1;
      m_k        = 1;
    end else if (acc && m_in_frame) begin
      m_k++;
      p = m_k + 1 - 2 * W;
      if (p >= 0) set_win(p);
      if (m_k == W * H) m_flush = 1;
    end
    e_border = c_BORDER_ON && e_wv && (e_x == 0 || e_x == W - 1 || e_y == 0 || e_y == H - 1);
    @(posedge clock);
    #1;
    check_val("win_valid", 32'(o_win_valid), 32'(e_wv));
    check_val("x",         32'(o_x),         32'(e_x));
    check_val("y",         32'(o_y),         32'(e_y));
    check_val("eof",       32'(o_eof),       32'(e_eof));
    check_val("border",    32'(o_border),    32'(e_border));
    if (o_win_valid) obs_win++;
    if (o_border) obs_border++;
  endtask

  // Send npix accepted pixels; sof on the first and on pixel abort_at.
  // vpct < 0 toggles valid every other cycle.
  task automatic send_frame(input int npix, input int vpct, input int abort_at, input bit rnd_pix);
    int  i;
    int  cyc;
    bit  v;
    bit  s;
    bit  will_acc;
    logic [PW-1:0] pix;
    i   = 0;
    cyc = 0;
    while (i < npix && cyc < 2000) begin
      if (vpct < 0) v = (cyc % 2 == 0);
      else          v = ($urandom_range(99) < vpct);
      s        = v && (i == 0 || i == abort_at);
      pix      = rnd_pix ? PW'($urandom) : PW'(i);
      will_acc = v && !m_flush;
      step(v, s, pix);
      if (will_acc) i++;
      cyc++;
    end
    if (i < npix) check_val("send_timeout", 32'(i), 32'(npix));
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while ((m_flush || m_in_frame) && cyc < 100) begin
      step(1'b0, 1'b0, PW'($urandom));
      cyc++;
    end
    if (m_flush || m_in_frame) check_val("drain_timeout", 32'd1, 32'd0);
    step(1'b0, 1'b0, '0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_win_valid"}, 32'(o_win_valid), 32'd0);
    check_val({tag, "_x"},         32'(o_x),         32'd0);
    check_val({tag, "_y"},         32'(o_y),         32'd0);
    check_val({tag, "_eof"},       32'(o_eof),       32'd0);
    check_val({tag, "_border"},    32'(o_border),    32'd0);
    check_val({tag, "_busy"},      32'(o_busy),      32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    i_pixel = '0;
    model_reset();
    clear_obs();
    repeat (2) @(posedge clock);
    #2;
    check_idle_outputs("rst");
    check_val("rst_ready", 32'(o_ready), 32'd1);
    reset = 1'b0;

    // 1: contiguous frame, pixel values 0..31
    clear_obs();
    send_frame(W * H, 100, -1, 1'b0);
    drain();
    check_val("t1_windows", 32'(obs_win), 32'(W * H));
    check_val("t1_flush_cycles", 32'(obs_flush), 32'(2 * W - 2));
    check_val("t6_border_count", 32'(obs_border), 32'(c_EXP_BORDER));

    // 2: valid toggling every other cycle
    clear_obs();
    send_frame(W * H, -1, -1, 1'b0);
    drain();
    check_val("t2_windows", 32'(obs_win), 32'(W * H));
    check_val("t2_flush_cycles", 32'(obs_flush), 32'(2 * W - 2));

    // 3: pixels without sof in IDLE are discarded, then a normal frame
    clear_obs();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, PW'($urandom));
    check_val("t3_no_windows", 32'(obs_win), 32'd0);
    send_frame(W * H, 100, -1, 1'b1);
    drain();
    check_val("t3_windows", 32'(obs_win), 32'(W * H));

    // 4: sof reasserted at pixel 20
    clear_obs();
    send_frame(20 + W * H, 100, 20, 1'b1);
    drain();
    check_val("t4_windows", 32'(obs_win), 32'(20 - (2 * W - 1) + 1 + W * H));

    // 5: asynchronous reset mid-RUN
    send_frame(24, 100, -1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("t5_rst");
    model_reset();
    #1;
    reset = 1'b0;
    clear_obs();
    send_frame(W * H, 100, -1, 1'b1);
    drain();
    check_val("t5_windows", 32'(obs_win), 32'(W * H));

    // Randomized frames with gaps, idle junk pixels and occasional aborts
    for (int f = 0; f < 8; f++) begin
      int ab;
      int nj;
      nj = $urandom_range(3);
      for (int j = 0; j < nj; j++) step(1'b1, 1'b0, PW'($urandom));
      ab = ($urandom_range(2) == 0) ? int'($urandom_range(1, W * H - 1)) : -1;
      send_frame((ab > 0) ? ab + W * H : W * H, int'($urandom_range(40, 100)), ab, 1'b1);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/buffer3_ctrl.md
Name: buffer3_ctrl

Overview:
Sequencer for the 3-line window buffer in the edge-detection path.
- Accepts the camera pixel stream with a valid/ready handshake.
- Generates the buffer's clock-enable and shift-in data.
- Tracks the frame position of the 3x3 window centre and qualifies it with a window-valid strobe.
- At end of frame, flushes the buffer with zero pixels so the last two rows are windowed before the next frame is accepted.

Parameters:
- WIDTH, 800, pixels per line; must equal the buffer's WIDTH.
- HEIGHT, 600, lines per frame.
- PIX_W, 30, pixel width (10 bits per RGB channel).
- CW, 12, width of the coordinate outputs; must satisfy 2^CW > max(WIDTH, HEIGHT).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- i_sof  in  1  start of frame; qualifies the pixel accepted in the same cycle.
- i_valid  in  1  input pixel valid.
- i_pixel  in  PIX_W  input RGB pixel.
- o_ready  out  1  controller accepts a pixel when i_valid & o_ready.
- buf_clken  out  1  drives the buffer's clken.
- buf_shiftin  out  PIX_W  drives the buffer's shiftin.
- o_win_valid  out  1  the buffer grid holds a complete window this cycle.
- o_x  out  CW  column of the grid centre (grid[4]).
- o_y  out  CW  row of the grid centre.
- o_eof  out  1  asserted together with the last window of the frame.
- o_border  out  1  the centre pixel lies on the frame border (optional feature).
- o_busy  out  1  state is not IDLE.

Behaviour:
- Reset values: state=IDLE, all counters 0, o_win_valid=0, o_eof=0, o_border=0, o_x=0, o_y=0.
- Reset is asynchronous and may assert mid-frame. Buffer contents are not cleared; the restarted counters guarantee no stale window is flagged valid.
- Combinational outputs:
  - buf_clken = (i_valid & o_ready) | (state==FLUSH).
  - buf_shiftin = i_pixel, or 0 in FLUSH.
- o_ready = 1 in IDLE, FILL and RUN; 0 in FLUSH.
- Shift counter k counts buffer shifts since frame start; k=1 on the sof pixel.
- Centre index p = k+1-2*WIDTH. A window is valid when p >= 0, i.e. k >= 2*WIDTH-1.
- o_win_valid, o_x, o_y, o_eof and o_border are registered on the same edge that shifts the buffer. They therefore describe oGrid during the following cycle(s).
- When buf_clken=0: o_win_valid drops to 0 and o_x/o_y hold.
- The buffer's shiftout tap is one shift stale. Consumers use grid[4] for the centre.
- States:
  - IDLE: pixels without i_sof are accepted and discarded (clken still pulses, k stays 0). An accepted pixel with i_sof sets k=1 and moves to FILL.
  - FILL: each accepted pixel increments k. On reaching k=2*WIDTH-1, set o_win_valid=1 with x=0, y=0 and go to RUN.
  - RUN: each shift sets o_win_valid=1. x increments and wraps at WIDTH-1 to 0 with y+1. When the input count reaches WIDTH*HEIGHT, go to FLUSH.
  - FLUSH: exactly 2*WIDTH-2 zero shifts, each producing a valid window. The last shift (x=WIDTH-1, y=HEIGHT-1) sets o_eof=1, then go to IDLE.
- Total shifts per frame: WIDTH*HEIGHT + 2*WIDTH - 2.
- i_sof seen in FILL or RUN: abort the current frame. The sof pixel becomes k=1, state goes to FILL, and o_win_valid is 0 on that edge.
- i_sof during FLUSH cannot be accepted because o_ready=0; upstream holds it.
- Input counter and coordinate counters are WIDTH/HEIGHT-bounded and never overflow.

Optional Feature:
- Macro: BUF3CTRL_BORDER_EN.
- Defined: o_border is registered alongside o_win_valid and asserts when x==0, x==WIDTH-1, y==0 or y==HEIGHT-1. The window wraps across lines or includes flushed zeros at those positions.
- Undefined: o_border is tied to 0 and the comparators are not built.

Decomposition:
- Package buf3_pkg holds:
  - WIDTH/HEIGHT defaults, selected by the VGA_640x480p60 define (640 vs 800 width; 480 vs 600 height).
  - PIX_W and CW.
  - State enum {IDLE, FILL, RUN, FLUSH}.
- One sub-module, wrap_counter: an x/y counter pair with enable, synchronous clear and a wrap flag. It is used for the centre coordinates and reused for the input count.

Test Plan (WIDTH=8, HEIGHT=4):
1. Reset, then 32 consecutive valid pixels (values 0..31) with i_sof on the first → first o_win_valid after the 15th shift with x=0, y=0 and grid[4]=0. o_ready low for exactly 14 flush cycles. 32 windows total; the last has x=7, y=3, o_eof=1 and grid[4]=31.
2. Same frame with i_valid toggling every other cycle → identical window sequence. o_win_valid is never high in a cycle that follows a cycle without a shift.
3. Pixels without i_sof while in IDLE → no o_win_valid and o_busy=0. A later i_sof starts the frame correctly.
4. i_sof reasserted at pixel 20 of a frame → o_win_valid=0 on that edge. The next valid window occurs 14 shifts later with x=0, y=0.
5. reset pulsed during RUN (asynchronously, mid-cycle) → all outputs 0 immediately, state IDLE. The next frame's first window appears after 15 shifts.
6. BUF3CTRL_BORDER_EN defined → o_border=1 for all x∈{0,7} or y∈{0,3} windows (20 of 32), and 0 for the 12 interior windows. Undefined → o_border always 0.
